// File: rtl/sub_pkg.sv
// Shared types and constants for the two-stage borrow-lookahead subtractor.
package sub_pkg;

    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;

    typedef logic [NIB_W-1:0] nib_t;

    // Contents of the stage-1 pipeline register: the untouched high-nibble
    // operands, the finished low-nibble difference and the borrow into bit 4.
    typedef struct packed {
        nib_t a_hi;
        nib_t b_hi;
        nib_t d_lo;
        logic br4;
    } s1_t;

endpackage

// File: rtl/bla_nibble.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bin.
// Every internal borrow is a flat sum of products of g/p/bin, so no borrow
// ripples through the slice. Group generate/propagate are exported so a
// higher-level lookahead can be built from several slices.
module bla_nibble
    import sub_pkg::*;
(
    input  nib_t a,
    input  nib_t b,
    input  logic bin,
    output nib_t d,
    output logic bout,
    output logic g_grp,
    output logic p_grp
);

    nib_t g_s;
    nib_t p_s;
    nib_t br_s;

    // A bit generates a borrow when a_i=0, b_i=1; it passes one on when a_i==b_i.
    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    assign br_s[0] = bin;
    assign br_s[1] = g_s[0] | (p_s[0] & bin);
    assign br_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign br_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                   | (p_s[2] & p_s[1] & p_s[0] & bin);

    assign g_grp = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign p_grp = &p_s;

    assign bout = g_grp | (p_grp & bin);
    assign d    = a ^ b ^ br_s;

endmodule

// File: rtl/borrow_lookahead_sub_pipe.sv
// Two-stage pipelined 8-bit subtractor, diff = a - b - bin, with valid/ready
// handshake on both sides. Stage 1 resolves the low nibble and the borrow into
// bit 4; stage 2 resolves the high nibble, borrow out, zero and signed overflow.
// Optional feature: define SUB_SAT_EN to clamp diff to 0 on unsigned underflow
// (zero then reads 1; bout and ovf still describe the raw result).
module borrow_lookahead_sub_pipe
    import sub_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       zero,
    output logic       ovf
);

    logic        adv1_s;
    logic        adv2_s;
    logic        load1_s;
    logic        load2_s;

    nib_t        d_lo_s;
    logic        br4_s;
    nib_t        d_hi_s;
    logic        br8_s;
    logic        lo_g_s;
    logic        lo_p_s;
    logic        hi_g_s;
    logic        hi_p_s;
    logic        unused_gp_s;

    s1_t         s1_next_s;
    logic [7:0]  raw_diff_s;
    logic [7:0]  diff_next_s;
    logic        zero_next_s;
    logic        ovf_next_s;

    logic        s1_valid_r;
    s1_t         s1_r;
    logic        s2_valid_r;
    logic [7:0]  diff_r;
    logic        bout_r;
    logic        zero_r;
    logic        ovf_r;

    // No skid buffer: a stage may advance when it is empty or its successor advances.
    assign adv2_s   = ~s2_valid_r | out_ready;
    assign adv1_s   = ~s1_valid_r | adv2_s;
    assign in_ready = adv1_s;
    assign load1_s  = in_valid & adv1_s;
    assign load2_s  = s1_valid_r & adv2_s;

    bla_nibble u_lo (
        .a     (a[3:0]),
        .b     (b[3:0]),
        .bin   (bin),
        .d     (d_lo_s),
        .bout  (br4_s),
        .g_grp (lo_g_s),
        .p_grp (lo_p_s)
    );

    bla_nibble u_hi (
        .a     (s1_r.a_hi),
        .b     (s1_r.b_hi),
        .bin   (s1_r.br4),
        .d     (d_hi_s),
        .bout  (br8_s),
        .g_grp (hi_g_s),
        .p_grp (hi_p_s)
    );

    // Group terms are not needed at this width; the slice bouts already use them.
    assign unused_gp_s = lo_g_s ^ lo_p_s ^ hi_g_s ^ hi_p_s;

    assign s1_next_s  = {a[7:4], b[7:4], d_lo_s, br4_s};
    assign raw_diff_s = {d_hi_s, s1_r.d_lo};

    // Stage-2 result terms; overflow always reflects the unsaturated difference.
    always_comb begin
        ovf_next_s  = (s1_r.a_hi[3] != s1_r.b_hi[3]) & (raw_diff_s[7] != s1_r.a_hi[3]);
        diff_next_s = raw_diff_s;
        zero_next_s = (raw_diff_s == 8'h00);
`ifdef SUB_SAT_EN
        if (br8_s) begin
            diff_next_s = 8'h00;
            zero_next_s = 1'b1;
        end else begin
            diff_next_s = raw_diff_s;
            zero_next_s = (raw_diff_s == 8'h00);
        end
`endif
    end

    // Stage 1: capture the low-nibble result and high-nibble operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else begin
            if (adv1_s) begin
                s1_valid_r <= in_valid;
            end
            if (load1_s) begin
                s1_r <= s1_next_s;
            end
        end
    end

    // Stage 2: capture the full result and flags; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            diff_r     <= 8'h00;
            bout_r     <= 1'b0;
            zero_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (adv2_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (load2_s) begin
                diff_r <= diff_next_s;
                bout_r <= br8_s;
                zero_r <= zero_next_s;
                ovf_r  <= ovf_next_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;

endmodule
